mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and the
// width of the port-A starvation counter.
// No ports; imported by mem_arbiter_if and mem_arbiter.
package rv32i_types;

  // Width of the counter that tracks consecutive port-B grants while A waits.
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the requester ports (A: instruction read, B: data read/write) and
// the shared memory port of the arbiter.
// slave modport = arbiter view; master modport = requesters + memory view.
interface mem_arbiter_if;
  import rv32i_types::*;

  // Port A (instruction fetch, read only)
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;

  // Port B (data, read or write)
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;

  // Shared physical memory
  logic        pmem_read;
  logic        pmem_write;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  modport slave (
    input  read_a, address_a, read_b, write, wmask, address_b, wdata,
           pmem_resp, pmem_rdata,
    output resp_a, rdata_a, resp_b, rdata_b,
           pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

  modport master (
    output read_a, address_a, read_b, write, wmask, address_b, wdata,
           pmem_resp, pmem_rdata,
    input  resp_a, rdata_a, resp_b, rdata_b,
           pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory between port A (instruction reads) and port B
// (data reads/writes); B has priority but A is granted after STARVE_LIMIT
// consecutive B grants while A waits. One transaction in flight at a time.
// Ports: clk, rst_n (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  // Transaction registers: the memory port is driven only from these, so a
  // requester changing its inputs mid-transaction has no effect.
  logic        owner_a_q;
  logic        is_wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_a_q;
  logic [31:0] rdata_b_q;

  logic req_b;
  logic grant_a;
  logic grant_b;

  assign req_b   = bus.read_b | bus.write;
  // A wins only when B is silent or B has used up its run of grants.
  assign grant_a = (state_q == IDLE) && bus.read_a && (!req_b || (starve_q == LIMIT));
  assign grant_b = (state_q == IDLE) && req_b && !grant_a;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d  = BUSY_A;
          starve_d = '0;
        end else if (grant_b) begin
          state_d = BUSY_B;
          if (!bus.read_a)            starve_d = '0;
          else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
        end
      end
      BUSY_A, BUSY_B: begin
        if (bus.pmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;  // bubble lets the requester drop or advance
      default: state_d = IDLE;
    endcase
  end

  // Transaction capture and read-data return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_a_q <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (grant_a) begin
        owner_a_q <= 1'b1;
        is_wr_q   <= 1'b0;
        addr_q    <= bus.address_a;
        wdata_q   <= '0;
        wmask_q   <= '0;
      end else if (grant_b) begin
        // Write takes precedence over a simultaneous read_b.
        owner_a_q <= 1'b0;
        is_wr_q   <= bus.write;
        addr_q    <= bus.address_b;
        wdata_q   <= bus.write ? bus.wdata : 32'd0;
        wmask_q   <= bus.write ? bus.wmask : 4'd0;
      end
      if ((state_q == BUSY_A) && bus.pmem_resp)
        rdata_a_q <= bus.pmem_rdata;
      if ((state_q == BUSY_B) && bus.pmem_resp && !is_wr_q)
        rdata_b_q <= bus.pmem_rdata;
    end
  end

  // Output logic
  always_comb begin
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.resp_a     = 1'b0;
    bus.resp_b     = 1'b0;
    case (state_q)
      BUSY_A: bus.pmem_read = 1'b1;
      BUSY_B: begin
        bus.pmem_read  = !is_wr_q;
        bus.pmem_write = is_wr_q;
      end
      DONE: begin
        bus.resp_a = owner_a_q;
        bus.resp_b = !owner_a_q;
      end
      default: ;
    endcase
  end

  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.pmem_wmask   = wmask_q;
  assign bus.rdata_a      = rdata_a_q;
  assign bus.rdata_b      = rdata_b_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_ph: 0 = no transaction, 1 = waiting for memory, 2 = reply cycle.
  int          m_ph;
  logic        m_own_a;
  logic        m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rda;
  logic [31:0] m_rdb;
  int          m_starve;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_own_a <= 1'b0; m_wr <= 1'b0; m_addr <= '0;
      m_wdata <= '0; m_wmask <= '0; m_rda <= '0; m_rdb <= '0; m_starve <= 0;
    end else if (m_ph == 0) begin
      if (bus.read_a && (!(bus.read_b || bus.write) || m_starve >= LIMIT)) begin
        m_ph <= 1; m_own_a <= 1'b1; m_wr <= 1'b0; m_addr <= bus.address_a;
        m_wdata <= '0; m_wmask <= '0; m_starve <= 0;
      end else if (bus.read_b || bus.write) begin
        m_ph <= 1; m_own_a <= 1'b0; m_wr <= bus.write; m_addr <= bus.address_b;
        m_wdata <= bus.write ? bus.wdata : 32'd0;
        m_wmask <= bus.write ? bus.wmask : 4'd0;
        m_starve <= bus.read_a ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end
    end else if (m_ph == 1) begin
      if (bus.pmem_resp) begin
        m_ph <= 2;
        if (m_own_a)    m_rda <= bus.pmem_rdata;
        else if (!m_wr) m_rdb <= bus.pmem_rdata;
      end
    end else begin
      m_ph <= 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("m_pmem_read",  bus.pmem_read,  (m_ph == 1) && !m_wr);
      chk1("m_pmem_write", bus.pmem_write, (m_ph == 1) && m_wr);
      chk1("m_resp_a",     bus.resp_a,     (m_ph == 2) && m_own_a);
      chk1("m_resp_b",     bus.resp_b,     (m_ph == 2) && !m_own_a);
      chk32("m_rdata_a",   bus.rdata_a,    m_rda);
      chk32("m_rdata_b",   bus.rdata_b,    m_rdb);
      if (m_ph == 1) begin
        chk32("m_pmem_address", bus.pmem_address, m_addr);
        chk32("m_pmem_wdata",   bus.pmem_wdata,   m_wdata);
        chk32("m_pmem_wmask",   32'(bus.pmem_wmask), 32'(m_wmask));
      end
      if (!rst_n) chk32("m_rst_address", bus.pmem_address, 32'd0);
    end
  end

  // Memory reply: dly negedges of waiting, then a one-cycle pmem_resp.
  // Returns at the negedge of the reply (DONE) cycle.
  task automatic serve(input int dly, input logic [31:0] rd);
    repeat (dly) @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.read_a = 1'b0; bus.address_a = '0;
    bus.read_b = 1'b0; bus.write = 1'b0; bus.wmask = '0;
    bus.address_b = '0; bus.wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk1("rst_pmem_read",  bus.pmem_read,  1'b0);
    chk1("rst_pmem_write", bus.pmem_write, 1'b0);
    chk1("rst_resp_a",     bus.resp_a,     1'b0);
    chk1("rst_resp_b",     bus.resp_b,     1'b0);
    chk32("rst_rdata_a",   bus.rdata_a,    32'd0);
    chk32("rst_rdata_b",   bus.rdata_b,    32'd0);
    chk32("rst_pmem_wdata", bus.pmem_wdata, 32'd0);
    chk32("rst_pmem_wmask", 32'(bus.pmem_wmask), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Port A read alone, memory answers 3 cycles after the strobe
    bus.read_a = 1'b1; bus.address_a = 32'h0000_0040;
    @(negedge clk);
    chk1("a_strobe", bus.pmem_read, 1'b1);
    chk32("a_addr", bus.pmem_address, 32'h0000_0040);
    serve(3, 32'hDEAD_BEEF);
    chk1("a_resp", bus.resp_a, 1'b1);
    chk1("a_no_resp_b", bus.resp_b, 1'b0);
    chk32("a_rdata", bus.rdata_a, 32'hDEAD_BEEF);
    chk1("a_strobe_off", bus.pmem_read, 1'b0);
    bus.read_a = 1'b0;
    @(negedge clk);
    chk1("a_resp_pulse", bus.resp_a, 1'b0);

    // A and a B write together: B first, then A
    bus.read_a = 1'b1; bus.address_a = 32'h0000_0200;
    bus.write = 1'b1; bus.address_b = 32'h0000_0100;
    bus.wdata = 32'h1234_5678; bus.wmask = 4'b0011;
    @(negedge clk);
    chk1("w_write", bus.pmem_write, 1'b1);
    chk1("w_read", bus.pmem_read, 1'b0);
    chk32("w_addr", bus.pmem_address, 32'h0000_0100);
    chk32("w_wdata", bus.pmem_wdata, 32'h1234_5678);
    chk32("w_wmask", 32'(bus.pmem_wmask), 32'h3);
    serve(1, 32'hCAFE_0000);
    chk1("w_resp_b", bus.resp_b, 1'b1);
    chk32("w_rdata_b_kept", bus.rdata_b, 32'd0);
    bus.write = 1'b0;
    @(negedge clk);
    chk1("w_bubble", bus.pmem_read, 1'b0);
    @(negedge clk);
    chk1("w_then_a", bus.pmem_read, 1'b1);
    chk32("w_then_a_addr", bus.pmem_address, 32'h0000_0200);
    serve(1, 32'hA5A5_0001);
    chk1("w_a_resp", bus.resp_a, 1'b1);
    chk32("w_a_rdata", bus.rdata_a, 32'hA5A5_0001);
    bus.read_a = 1'b0;
    @(negedge clk);

    // Starvation: A held while B reads back to back
    bus.read_a = 1'b1; bus.address_a = 32'h0000_0300;
    bus.read_b = 1'b1; bus.address_b = 32'h0000_0400;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk32("st_addr", bus.pmem_address, (i == 4) ? 32'h0000_0300 : 32'h0000_0400);
      chk1("st_read", bus.pmem_read, 1'b1);
      bus.pmem_resp = 1'b1; bus.pmem_rdata = 32'(i + 16);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      chk1("st_resp_a", bus.resp_a, i == 4);
      chk1("st_resp_b", bus.resp_b, i != 4);
      if (i == 5) begin bus.read_a = 1'b0; bus.read_b = 1'b0; end
      repeat (2) @(negedge clk);
    end

    // read_b and write both high: write wins; requests dropped mid-flight
    bus.read_b = 1'b1; bus.write = 1'b1; bus.address_b = 32'h0000_0500;
    bus.wdata = 32'hFFFF_0000; bus.wmask = 4'b1111;
    @(negedge clk);
    chk1("rw_write", bus.pmem_write, 1'b1);
    chk1("rw_read", bus.pmem_read, 1'b0);
    chk32("rw_wmask", 32'(bus.pmem_wmask), 32'hF);
    bus.read_b = 1'b0; bus.write = 1'b0; bus.address_b = 32'h0000_0999; bus.wdata = '0;
    serve(2, 32'h7777_7777);
    chk1("rw_resp_b", bus.resp_b, 1'b1);
    chk32("rw_rdata_b_kept", bus.rdata_b, 32'd21);
    @(negedge clk);

    // Reset while BUSY_A, memory answers during reset
    bus.read_a = 1'b1; bus.address_a = 32'h0000_0600;
    @(negedge clk);
    chk1("r_strobe", bus.pmem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("r_pmem_read", bus.pmem_read, 1'b0);
    chk32("r_addr", bus.pmem_address, 32'd0);
    chk32("r_rdata_a", bus.rdata_a, 32'd0);
    chk32("r_rdata_b", bus.rdata_b, 32'd0);
    chk1("r_resp_a", bus.resp_a, 1'b0);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 32'h0000_0BAD;
    repeat (2) @(negedge clk);
    bus.pmem_resp = 1'b0; bus.read_a = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("r_no_resp_a", bus.resp_a, 1'b0);
      chk1("r_idle", bus.pmem_read, 1'b0);
    end
    bus.read_b = 1'b1; bus.address_b = 32'h0000_0700;
    @(negedge clk);
    chk1("r_regrant", bus.pmem_read, 1'b1);
    chk32("r_regrant_addr", bus.pmem_address, 32'h0000_0700);
    bus.read_b = 1'b0;
    serve(0, 32'h0000_1111);
    @(negedge clk);

    // Randomized traffic, checked by the every-cycle model compare
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) #2 rst_n = 1'b0;
      if (!bus.read_a) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.read_a = 1'b1; bus.address_a = $urandom;
        end
      end else if ((m_ph == 2) && m_own_a) begin
        if ($urandom_range(0, 1) == 0) bus.read_a = 1'b0;
        else bus.address_a = $urandom;
      end else if ($urandom_range(0, 59) == 0) begin
        bus.read_a = 1'b0;
      end
      bus.read_b    = ($urandom_range(0, 2) != 0);
      bus.write     = ($urandom_range(0, 3) == 0);
      bus.address_b = $urandom;
      bus.wdata     = $urandom;
      bus.wmask     = 4'($urandom_range(0, 15));
      bus.pmem_resp = ($urandom_range(0, 2) == 0);
      bus.pmem_rdata = $urandom;
    end

    @(negedge clk);
    rst_n = 1'b1;
    bus.read_a = 1'b0; bus.read_b = 1'b0; bus.write = 1'b0; bus.pmem_resp = 1'b1;
    repeat (4) @(negedge clk);
    bus.pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk1("end_idle_read", bus.pmem_read, 1'b0);
    chk1("end_idle_write", bus.pmem_write, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
